// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// RV32I opcodes, command classes, loader states and immediate range helpers.
package imem_program_loader_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_JALR = 3'd6,
    CLS_RSVD = 3'd7
  } cmd_class_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_e;

  // True when the 21-bit signed immediate lies in [-2048, 2047].
  function automatic logic fits_simm12(input logic [20:0] imm);
    return (imm[20:11] == '0) || (imm[20:11] == '1);
  endfunction

  // True when the 21-bit signed immediate lies in [-4096, 4095].
  function automatic logic fits_simm13(input logic [20:0] imm);
    return (imm[20:12] == '0) || (imm[20:12] == '1);
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Command stream from the boot host and the imem write port of the loader.
// The host side is the master; the loader is the slave.
interface imem_program_loader_if #(
  parameter int ADDR_W = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_class;
  logic [2:0]        cmd_funct3;
  logic              cmd_funct7b5;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [20:0]       cmd_imm;
  logic              cmd_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output cmd_valid, cmd_class, cmd_funct3, cmd_funct7b5,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_class, cmd_funct3, cmd_funct7b5,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader_instr_encode.sv
// Combinational RV32I encoder: turns a field-level command into a 32-bit
// instruction word and flags commands whose immediate or class cannot be encoded.
module instr_encode
  import imem_program_loader_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Per-class bit packing and immediate legality; shifts carry shamt in imm[4:0].
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cmd_class_e'(cls))
      CLS_R: begin
        word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, R_TYPE};
      end
      CLS_I: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          word    = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, I_TYPE};
          illegal = (imm[20:5] != '0);
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, I_TYPE};
          illegal = !fits_simm12(imm);
        end
      end
      CLS_LW: begin
        word    = {imm[11:0], rs1, 3'b010, rd, LW};
        illegal = !fits_simm12(imm);
      end
      CLS_SW: begin
        word    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], SW};
        illegal = !fits_simm12(imm);
      end
      CLS_BR: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], BR};
        illegal = !fits_simm13(imm) || imm[0];
      end
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
        illegal = imm[0];
      end
      CLS_JALR: begin
        word    = {imm[11:0], rs1, 3'b000, rd, JALR};
        illegal = !fits_simm12(imm);
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time program loader: accepts encoded-instruction commands, writes them
// sequentially into imem and keeps the core in reset until the session completes.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  imem_program_loader_if.slave  bus,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       word_count
);

  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_hold_q, core_hold_d;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;

  instr_encode u_encode (
    .cls      (bus.cmd_class),
    .funct3   (bus.cmd_funct3),
    .funct7b5 (bus.cmd_funct7b5),
    .rd       (bus.cmd_rd),
    .rs1      (bus.cmd_rs1),
    .rs2      (bus.cmd_rs2),
    .imm      (bus.cmd_imm),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  assign accept = bus.cmd_valid & cmd_ready_q;

  // Next-state, write-port and status computation; outputs follow the next state.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (enc_illegal) begin
            state_d = ST_ERR;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = BASE + count_q[ADDR_W-1:0];
            imem_wdata_d = enc_word;
            count_d      = count_q + (ADDR_W+1)'(1);
            if (bus.cmd_last) begin
              state_d = ST_FLUSH;
            end
          end
        end else if (bus.cmd_valid && count_q == DEPTH) begin
          state_d = ST_ERR;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_LOAD) && (count_d < DEPTH);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
    core_hold_d = (state_d != ST_DONE);
  end

  // State, counter and registered outputs; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE;
      imem_wdata_q <= '0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_hold_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_hold_q  <= core_hold_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_hold      = core_hold_q;
  assign done           = done_q;
  assign err            = err_q;
  assign word_count     = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the program loader: a default-size instance for the
// encoding and session scenarios, and a 4-word instance for the overflow case.
module tb_imem_program_loader;

  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_SW = 3'd3, C_BR = 3'd4, C_JAL = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       core_hold, done, err;
  logic [9:0] word_count;
  logic       start2 = 1'b0;
  logic       core_hold2, done2, err2;
  logic [2:0] word_count2;
  int         checks = 0;
  int         errors = 0;
  int         writes2 = 0;

  imem_program_loader_if #(.ADDR_W(9)) ifc ();
  imem_program_loader_if #(.ADDR_W(2)) ifc2 ();

  imem_program_loader #(.ADDR_W(9), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(ifc),
    .core_hold(core_hold), .done(done), .err(err), .word_count(word_count)
  );

  imem_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(ifc2),
    .core_hold(core_hold2), .done(done2), .err(err2), .word_count(word_count2)
  );

  always #5 clk = ~clk;

  // Counts write strobes from the small instance.
  always @(posedge clk) begin
    if (ifc2.imem_we === 1'b1) writes2++;
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    ifc.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one command, waits (bounded) for ready, returns 1ns after the accepting edge.
  task automatic do_cmd(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [20:0] imm, input logic last);
    int n;
    @(negedge clk);
    ifc.cmd_class = cls; ifc.cmd_funct3 = f3; ifc.cmd_funct7b5 = f7;
    ifc.cmd_rd = rd; ifc.cmd_rs1 = rs1; ifc.cmd_rs2 = rs2;
    ifc.cmd_imm = imm; ifc.cmd_last = last; ifc.cmd_valid = 1'b1;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ifc.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_timeout: got %b expected 1", ifc.cmd_ready);
    end
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ifc.imem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %b expected 0", ifc.imem_we); end
    checks++; if (ifc.imem_addr !== 9'd0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0", ifc.imem_addr); end
    checks++; if (ifc.imem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_wdata: got %h expected 0", ifc.imem_wdata); end
    checks++; if (ifc.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", ifc.cmd_ready); end
    checks++; if ({done, err, core_hold} !== 3'b001) begin errors++; $display("[TB] FAIL rst_status: got %b expected 001", {done, err, core_hold}); end
    checks++; if (word_count !== 10'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", word_count); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ifc.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 0", ifc.cmd_ready); end
  endtask

  task automatic test_single_addi();
    pulse_start();
    checks++; if (ifc.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_ready: got %b expected 1", ifc.cmd_ready); end
    do_cmd(C_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    checks++; if (ifc.imem_we !== 1'b1) begin errors++; $display("[TB] FAIL addi_we: got %b expected 1", ifc.imem_we); end
    checks++; if (ifc.imem_addr !== 9'd0) begin errors++; $display("[TB] FAIL addi_addr: got %h expected 0", ifc.imem_addr); end
    checks++; if (ifc.imem_wdata !== 32'h00500093) begin errors++; $display("[TB] FAIL addi_wdata: got %h expected 00500093", ifc.imem_wdata); end
    @(posedge clk); #1;
    checks++; if (ifc.imem_we !== 1'b0) begin errors++; $display("[TB] FAIL addi_we_drop: got %b expected 0", ifc.imem_we); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    pulse_start();
    do_cmd(C_R, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    checks++; if ({ifc.imem_we, ifc.imem_addr, ifc.imem_wdata} !== {1'b1, 9'd0, 32'h002081B3}) begin errors++; $display("[TB] FAIL b2b_add: got %b/%h/%h expected 1/000/002081b3", ifc.imem_we, ifc.imem_addr, ifc.imem_wdata); end
    do_cmd(C_SW, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0);
    checks++; if ({ifc.imem_we, ifc.imem_addr, ifc.imem_wdata} !== {1'b1, 9'd1, 32'h0020A423}) begin errors++; $display("[TB] FAIL b2b_sw: got %b/%h/%h expected 1/001/0020a423", ifc.imem_we, ifc.imem_addr, ifc.imem_wdata); end
    do_cmd(C_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b0);
    checks++; if ({ifc.imem_we, ifc.imem_addr, ifc.imem_wdata} !== {1'b1, 9'd2, 32'hFE208EE3}) begin errors++; $display("[TB] FAIL b2b_beq: got %b/%h/%h expected 1/002/fe208ee3", ifc.imem_we, ifc.imem_addr, ifc.imem_wdata); end
    do_cmd(C_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1);
    checks++; if ({ifc.imem_we, ifc.imem_addr, ifc.imem_wdata} !== {1'b1, 9'd3, 32'h008000EF}) begin errors++; $display("[TB] FAIL b2b_jal: got %b/%h/%h expected 1/003/008000ef", ifc.imem_we, ifc.imem_addr, ifc.imem_wdata); end
    checks++; if ({done, core_hold, ifc.cmd_ready} !== 3'b010) begin errors++; $display("[TB] FAIL flush_status: got %b expected 010", {done, core_hold, ifc.cmd_ready}); end
    @(posedge clk); #1;
    checks++; if ({done, err, core_hold} !== 3'b100) begin errors++; $display("[TB] FAIL done_status: got %b expected 100", {done, err, core_hold}); end
    checks++; if (word_count !== 10'd4) begin errors++; $display("[TB] FAIL done_count: got %0d expected 4", word_count); end
    checks++; if ({ifc.imem_we, ifc.cmd_ready} !== 2'b00) begin errors++; $display("[TB] FAIL done_quiet: got %b expected 00", {ifc.imem_we, ifc.cmd_ready}); end
  endtask

  task automatic test_restart_from_done();
    pulse_start();
    checks++; if ({done, core_hold, ifc.cmd_ready} !== 3'b011) begin errors++; $display("[TB] FAIL restart_status: got %b expected 011", {done, core_hold, ifc.cmd_ready}); end
    checks++; if (word_count !== 10'd0) begin errors++; $display("[TB] FAIL restart_count: got %0d expected 0", word_count); end
    do_cmd(C_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 21'd7, 1'b0);
    checks++; if ({ifc.imem_we, ifc.imem_addr, ifc.imem_wdata} !== {1'b1, 9'd0, 32'h00700113}) begin errors++; $display("[TB] FAIL restart_write: got %b/%h/%h expected 1/000/00700113", ifc.imem_we, ifc.imem_addr, ifc.imem_wdata); end
  endtask

  task automatic test_illegal_branch();
    reset_dut();
    pulse_start();
    do_cmd(C_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0);
    checks++; if (ifc.imem_we !== 1'b0) begin errors++; $display("[TB] FAIL odd_br_we: got %b expected 0", ifc.imem_we); end
    checks++; if ({err, core_hold, done, ifc.cmd_ready} !== 4'b1100) begin errors++; $display("[TB] FAIL odd_br_status: got %b expected 1100", {err, core_hold, done, ifc.cmd_ready}); end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({ifc.imem_we, err, ifc.cmd_ready} !== 3'b010) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 010", {ifc.imem_we, err, ifc.cmd_ready}); end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifc2.cmd_class = C_I; ifc2.cmd_funct3 = 3'b000; ifc2.cmd_funct7b5 = 1'b0;
      ifc2.cmd_rd = 5'(i + 1); ifc2.cmd_rs1 = 5'd0; ifc2.cmd_rs2 = 5'd0;
      ifc2.cmd_imm = 21'(i); ifc2.cmd_last = 1'b0; ifc2.cmd_valid = 1'b1;
      @(posedge clk); #1;
      ifc2.cmd_valid = 1'b0;
      checks++; if ({ifc2.imem_we, ifc2.imem_addr} !== {1'b1, 2'(i)}) begin errors++; $display("[TB] FAIL ovf_write%0d: got %b/%h expected 1/%h", i, ifc2.imem_we, ifc2.imem_addr, 2'(i)); end
    end
    checks++; if ({ifc2.cmd_ready, err2} !== 2'b00) begin errors++; $display("[TB] FAIL ovf_full: got %b expected 00", {ifc2.cmd_ready, err2}); end
    checks++; if (word_count2 !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", word_count2); end
    @(negedge clk);
    ifc2.cmd_valid = 1'b1;
    @(posedge clk); #1;
    ifc2.cmd_valid = 1'b0;
    checks++; if ({err2, core_hold2, ifc2.imem_we} !== 3'b110) begin errors++; $display("[TB] FAIL ovf_err: got %b expected 110", {err2, core_hold2, ifc2.imem_we}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (writes2 !== 4) begin errors++; $display("[TB] FAIL ovf_writes: got %0d expected 4", writes2); end
  endtask

  task automatic test_mid_load_reset();
    reset_dut();
    pulse_start();
    do_cmd(C_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    checks++; if (ifc.imem_we !== 1'b1) begin errors++; $display("[TB] FAIL mid_we_pre: got %b expected 1", ifc.imem_we); end
    reset = 1'b1;
    ifc.cmd_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ifc.imem_we, ifc.cmd_ready, done, err, core_hold} !== 5'b00001) begin errors++; $display("[TB] FAIL mid_rst_status: got %b expected 00001", {ifc.imem_we, ifc.cmd_ready, done, err, core_hold}); end
    checks++; if ({ifc.imem_addr, ifc.imem_wdata, word_count} !== {9'd0, 32'h0, 10'd0}) begin errors++; $display("[TB] FAIL mid_rst_regs: got %h/%h/%0d expected 0/0/0", ifc.imem_addr, ifc.imem_wdata, word_count); end
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_class = '0; ifc.cmd_funct3 = '0; ifc.cmd_funct7b5 = 1'b0;
    ifc.cmd_rd = '0; ifc.cmd_rs1 = '0; ifc.cmd_rs2 = '0; ifc.cmd_imm = '0; ifc.cmd_last = 1'b0;
    ifc2.cmd_valid = 1'b0; ifc2.cmd_class = '0; ifc2.cmd_funct3 = '0; ifc2.cmd_funct7b5 = 1'b0;
    ifc2.cmd_rd = '0; ifc2.cmd_rs1 = '0; ifc2.cmd_rs2 = '0; ifc2.cmd_imm = '0; ifc2.cmd_last = 1'b0;
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_restart_from_done();
    test_illegal_branch();
    test_overflow();
    test_mid_load_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
